phase_timer: RTL
================

# phase_timer

Upstream timing stage for the traffic-light state converter. Divides the system clock into one-second ticks, loads a per-phase duration selected by the converter's current 3-bit light code and mode `M`, and counts it down. At expiry it emits a one-cycle `step` pulse that drives the converter's clock input. It also exports the remaining seconds, in binary and BCD, for the countdown display.

## Interface
Parameters:
- `TICK_DIV`, default 4: `clk` cycles per second tick (≥2; 4 for simulation, the board value for hardware).
- `DUR_TABLE`, default 32'h1232_5320: eight 4-bit durations in seconds; nibble i (bits 4i+3:4i) applies to light code i.
- `FLASH_S`, default 1: duration in seconds for every phase while `M`=1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `CR`  in  1  reset; one clock, asynchronous and active-high.
- `M`  in  1  mode select, same signal that feeds the converter.
- `state_in`  in  3  current light code from the converter's `data`.
- `hold`  in  1  freezes the countdown while high (COUNT state only).
- `step`  out  1  registered one-cycle advance pulse to the converter clock.
- `sec_tick`  out  1  high for the one cycle in which a second elapses.
- `remain`  out  4  seconds remaining in the current phase (0–15).
- `remain_tens`  out  4  BCD tens of `remain` (0 or 1).
- `remain_ones`  out  4  BCD ones of `remain` (0–9).

## Operation
- FSM states: RST_WAIT, LOAD, COUNT, STEP.
- Reset values: state RST_WAIT, prescaler 0, `remain`=0, `step`=0, `sec_tick`=0, and BCD outputs 0/0.
- RST_WAIT: lasts one cycle, then goes to LOAD.
- LOAD:
  - Samples `state_in` and `M`.
  - Sets `remain` ← dur, where dur = `M` ? `FLASH_S` : `DUR_TABLE`[4·`state_in` +: 4].
  - A dur of 0 is forced to 1.
  - Clears the prescaler to 0 and goes to COUNT.
- COUNT:
  - When `hold`=0, the prescaler increments each cycle.
  - When prescaler = `TICK_DIV`−1, `sec_tick`=1 and the prescaler wraps to 0.
  - On a tick with `remain`>1: `remain` decrements.
  - On a tick with `remain`=1: `remain` ← 0 and the FSM goes to STEP.
  - When `hold`=1, the prescaler, `remain` and state are all frozen and `sec_tick`=0.
- STEP: `step`=1 for exactly this cycle, then go to LOAD.
  - `hold` has no effect in STEP or LOAD.
- Outputs:
  - `step` is a flop output (glitch-free, safe to use as a clock).
  - `sec_tick` is asserted only in COUNT.
- BCD outputs: `remain_tens` = (`remain` ≥ 10), `remain_ones` = `remain` mod 10. Both are combinational from the `remain` register.
- Changes on `M` or `state_in` during COUNT or STEP are ignored until the next LOAD.
- `CR` asserted mid-phase: all state returns to reset values immediately. No `step` is emitted for the aborted phase.

## Timing
- The converter updates its code on the rising edge of `step`. LOAD samples `state_in` two `clk` edges later, so the new code is already stable.
- Phase period, from the `step` rising edge to the next `step` rising edge: dur·`TICK_DIV` + 2 cycles, with `hold` low.
- First `step` after `CR` deasserts: rises at the (dur·`TICK_DIV` + 2)-th clock edge, where dur comes from the code present at LOAD.
- Each cycle of `hold`=1 in COUNT lengthens the phase by exactly one cycle.
- `remain` changes only on a LOAD edge or a tick edge.

## Test plan
- Reset, `TICK_DIV`=4, `state_in`=7, `M`=0, default table: `remain`=0 and `step`=0 during reset. After release, `remain`=1 at edge 2 and `step` rises at edge 6, high for one cycle. `sec_tick` pulses once, at the cycle before edge 6.
- Steady cycling, `state_in` held at 4 (dur 2): `step` period = 10 cycles. `remain` sequence is 2, 1, 0. `sec_tick` fires every 4 cycles within COUNT.
- Code 0 (table nibble 0) → treated as 1 s: period 6 cycles. Code 3 → `remain`=5, period 22.
- `M`=1 with `FLASH_S`=1 for every code → period 6. `M` toggled mid-COUNT → current phase unchanged; the new duration applies from the next LOAD.
- `hold`=1 for 7 cycles mid-COUNT: `remain` and the prescaler freeze, no `sec_tick`, and the period grows by exactly 7. `hold`=1 during STEP → `step` still pulses.
- `CR` pulsed while `remain`=3 in a 5 s phase: outputs are immediately 0 and no `step` is emitted. The restart follows the reset timing above. Also with `DUR_TABLE` nibble = 12: `remain_tens`/`remain_ones` show 1/2, then 1/1, 1/0, 0/9.

Source files
------------

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase countdown timer producing the converter step pulse
//
// Purpose: divides clk into one-second ticks, loads a phase duration chosen by
// the converter's current light code (or the flash duration in mode M), counts
// it down and emits a one-cycle registered step pulse at expiry.
//
// Ports:
//   clk          in   system clock, rising edge
//   CR           in   asynchronous active-high reset
//   M            in   mode select (1 = flash duration for every phase)
//   state_in     in   [2:0] current light code from the converter
//   hold         in   freezes the countdown while high (COUNT only)
//   step         out  registered one-cycle advance pulse
//   sec_tick     out  high in the COUNT cycle in which a second elapses
//   remain       out  [3:0] seconds remaining in the current phase
//   remain_tens  out  [3:0] BCD tens of remain
//   remain_ones  out  [3:0] BCD ones of remain

module phase_timer #(
   parameter int          TICK_DIV  = 4,
   parameter logic [31:0] DUR_TABLE = 32'h1232_5320,
   parameter int          FLASH_S   = 1
) (
   input  logic       clk,
   input  logic       CR,
   input  logic       M,
   input  logic [2:0] state_in,
   input  logic       hold,
   output logic       step,
   output logic       sec_tick,
   output logic [3:0] remain,
   output logic [3:0] remain_tens,
   output logic [3:0] remain_ones
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [3:0]    FLASH_DUR = 4'(FLASH_S);

   typedef enum logic [1:0] {
      RST_WAIT,
      LOAD,
      COUNT,
      STEP
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pre, pre_nxt;
   logic [3:0]    remain_nxt;
   logic          step_nxt;
   logic [3:0]    dur_raw;
   logic [3:0]    dur;

   // Duration lookup; a zero entry would never expire, so it is treated as 1 s.
   always_comb begin
      dur_raw = M ? FLASH_DUR : DUR_TABLE[{state_in, 2'b00} +: 4];
      dur     = (dur_raw == 4'd0) ? 4'd1 : dur_raw;
   end

   always_comb begin
      state_nxt  = state;
      pre_nxt    = pre;
      remain_nxt = remain;
      step_nxt   = 1'b0;
      sec_tick   = 1'b0;
      case (state)
         RST_WAIT: state_nxt = LOAD;
         LOAD: begin
            remain_nxt = dur;
            pre_nxt    = '0;
            state_nxt  = COUNT;
         end
         COUNT: begin
            if (!hold) begin
               if (pre == PRE_MAX) begin
                  sec_tick = 1'b1;
                  pre_nxt  = '0;
                  if (remain > 4'd1) begin
                     remain_nxt = remain - 4'd1;
                  end else begin
                     remain_nxt = 4'd0;
                     state_nxt  = STEP;
                     // step is registered so it rises on the same edge STEP is entered
                     step_nxt   = 1'b1;
                  end
               end else begin
                  pre_nxt = pre + 1'b1;
               end
            end
         end
         STEP: state_nxt = LOAD;
         default: state_nxt = RST_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge CR) begin
      if (CR) begin
         state  <= RST_WAIT;
         pre    <= '0;
         remain <= 4'd0;
         step   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pre    <= pre_nxt;
         remain <= remain_nxt;
         step   <= step_nxt;
      end
   end

   always_comb begin
      remain_tens = (remain >= 4'd10) ? 4'd1 : 4'd0;
      remain_ones = (remain >= 4'd10) ? (remain - 4'd10) : remain;
   end

endmodule
